ob_table_fifo: RTL and testbench
================================

Name: ob_table_fifo

Overview:
- Parametrised successor to the single-sided order-book table: a sorted, depth-N, price-time-priority table of resting orders for one side (bid or ask).
- New relative to the prior generation:
  - equal prices keep arrival order (FIFO among ties);
  - in-place quantity amend by UID;
  - partial fills at the head with automatic pop on exhaustion;
  - occupancy count and full flag;
  - a ready/valid command handshake that back-pressures while the reject slot is occupied.
- Sits between the order-book controller and the match engine; one instance per side.

Parameters:
- N, 16, number of resting entries (head = slot N-1); N >= 2.
- IS_ASK, 1, 1 = ask side (ascending price at head), 0 = bid side (descending).
- CNT_W, $clog2(N+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; equals !reject_vld_r
- cmd_op  in  ob_pkg::tbl_op_t  INSERT, CANCEL, AMEND, FILL
- cmd_tbl  in  ob_pkg::table_t  INSERT payload
- cmd_uid  in  ob_pkg::uid_t  CANCEL/AMEND target
- cmd_qty  in  ob_pkg::quantity_t  AMEND new quantity / FILL quantity
- rsp_vld_r  out  1  response valid, one cycle after command accept
- rsp_hit_r  out  1  CANCEL/AMEND found its UID; FILL had a valid head
- rsp_tbl_r  out  ob_pkg::table_t  removed/amended/filled entry, pre-update value
- rsp_rem_r  out  ob_pkg::quantity_t  FILL quantity left unconsumed
- head_vld_r  out  1  head entry valid
- head_r  out  ob_pkg::table_t  head entry
- reject_vld_r  out  1  reject slot holds an entry
- reject_r  out  ob_pkg::table_t  rejected entry
- reject_pop  in  1  controller consumes reject slot
- occ_r  out  CNT_W  number of valid resting entries
- full_r  out  1  occ_r == N

Behaviour:
- Reset: all slots invalid, with price = PRICE_MAX (ask) or PRICE_MIN (bid). All outputs 0; occ_r = 0; cmd_rdy = 1.
- Accept rule: a command executes on a cycle with cmd_vld & cmd_rdy. Results are visible in registered outputs the next cycle (latency 1). At most one command per cycle.
- INSERT:
  - Insertion slot is below every valid entry whose price is better-or-equal; equality keeps the older entry nearer the head.
  - Entries from the insertion slot toward the tail shift down one place.
  - If full_r, the entry evicted from the tail goes to the reject slot; it may be the incoming order itself if it ranks worst.
  - occ_r increments unless full_r.
  - rsp_hit_r = 0.
- CANCEL:
  - Matching valid entry is removed; entries tailward of it shift up; occ_r decrements.
  - Miss: no state change, rsp_hit_r = 0.
- AMEND:
  - Matching entry's quantity is replaced; position and time priority are kept.
  - cmd_qty == 0 behaves exactly as CANCEL.
- FILL:
  - If cmd_qty < head quantity: head quantity -= cmd_qty, rsp_rem_r = 0.
  - Otherwise the head is popped (table shifts up, occ_r decrements) and rsp_rem_r = cmd_qty - head quantity.
  - Empty table: rsp_hit_r = 0, rsp_rem_r = cmd_qty.
- Quantity arithmetic: unsigned at ob_pkg quantity width; no wrap is possible because subtraction only happens when the result is non-negative.
- Reject slot:
  - reject_pop clears reject_vld_r next cycle.
  - reject_pop may coincide with any accepted command.
  - cmd_rdy stays low while reject_vld_r; an eviction therefore can never overwrite a pending reject.
- UID uniqueness is a controller obligation; the bench asserts at most one UID match.
- rst asserted mid-operation wins over any in-flight command; the command is dropped and no response is issued.

Decomposition:
- ob_pkg additions:
  - tbl_op_t enum (INSERT, CANCEL, AMEND, FILL);
  - per-side invalid-price constants.
- Sub-module ob_table_slot holds one entry and register with a next-state mux. Sources: hold, self-amend, take from head-side neighbour, take from tail-side neighbour, install from cmd_tbl. It is driven by one-hot select vectors from the parent.
- The parent computes the compare, priority and mask vectors, the reject and response registers, and the occ_r counter.

Test Plan:
- Ask, N=4:
  - Insert prices 105, 101, 103 -> head 101, slot order 101/103/105, occ_r=3.
  - Insert 103 with uid 9 -> uid 9 sits behind the earlier 103 entry.
- Ask, full table [101,102,103,104], insert 100 -> 104 moves to reject, cmd_rdy=0 next cycle. reject_pop -> cmd_rdy=1 the following cycle.
- Full table, insert 110 -> the inserted entry itself is rejected; table unchanged; occ_r=4.
- Head qty 50:
  - FILL 20 -> head qty 30, rsp_rem_r=0.
  - FILL 45 -> head popped, rsp_rem_r=15, occ_r decrements.
  - FILL on empty table -> rsp_hit_r=0, rsp_rem_r=qty.
- Cancel/amend by UID:
  - CANCEL of the middle UID -> tail shifts up.
  - AMEND uid to qty 7 -> same slot, new quantity.
  - AMEND to 0 -> removed.
  - CANCEL of an absent uid -> rsp_hit_r=0, no state change.
- Bid instance, N=8, reset asserted while FILL is accepted -> next cycle all outputs 0, occ_r=0, no rsp_vld_r.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared types and helpers for the single-side price-time-priority order table.
package ob_pkg;

    localparam int unsigned UID_W   = 8;
    localparam int unsigned PRICE_W = 16;
    localparam int unsigned QTY_W   = 16;

    typedef logic [UID_W-1:0]   uid_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [QTY_W-1:0]   quantity_t;

    // Prices parked in empty slots so they never rank ahead of a real order
    localparam price_t PRICE_MAX = '1;
    localparam price_t PRICE_MIN = '0;

    typedef enum logic [1:0] {
        INSERT = 2'd0,
        CANCEL = 2'd1,
        AMEND  = 2'd2,
        FILL   = 2'd3
    } tbl_op_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t qty;
    } table_t;

    typedef struct packed {
        logic   vld;
        table_t tbl;
    } slot_t;

    // Invalid-price constant for the given side
    function automatic price_t invalid_price(input bit is_ask);
        return is_ask ? PRICE_MAX : PRICE_MIN;
    endfunction

    // Contents of an empty slot for the given side
    function automatic slot_t empty_slot(input bit is_ask);
        slot_t s;
        s           = '0;
        s.tbl.price = invalid_price(is_ask);
        return s;
    endfunction

    // True when a resting price stays ahead of an incoming one (ties favour the resting order)
    function automatic logic ranks_ahead(input bit is_ask, input price_t rest, input price_t incoming);
        return is_ask ? (rest <= incoming) : (rest >= incoming);
    endfunction

    // Next value of one slot given its one-hot source selects
    function automatic slot_t slot_next(
        input slot_t     cur,
        input logic      sel_ins,
        input logic      sel_head,
        input logic      sel_tail,
        input logic      sel_amend,
        input table_t    ins_tbl,
        input slot_t     head_nb,
        input slot_t     tail_nb,
        input quantity_t amend_qty
    );
        slot_t nxt;
        nxt = cur;
        if (sel_ins) begin
            nxt.vld = 1'b1;
            nxt.tbl = ins_tbl;
        end else if (sel_head) begin
            nxt = head_nb;
        end else if (sel_tail) begin
            nxt = tail_nb;
        end else if (sel_amend) begin
            nxt.tbl.qty = amend_qty;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ob_table_fifo_if.sv
// Command, response, head, reject and status bundle between controller and table.
interface ob_table_fifo_if #(
    parameter int unsigned CNT_W = 5
) ();
    logic              cmd_vld;
    logic              cmd_rdy;
    ob_pkg::tbl_op_t   cmd_op;
    ob_pkg::table_t    cmd_tbl;
    ob_pkg::uid_t      cmd_uid;
    ob_pkg::quantity_t cmd_qty;

    logic              rsp_vld_r;
    logic              rsp_hit_r;
    ob_pkg::table_t    rsp_tbl_r;
    ob_pkg::quantity_t rsp_rem_r;

    logic              head_vld_r;
    ob_pkg::table_t    head_r;

    logic              reject_vld_r;
    ob_pkg::table_t    reject_r;
    logic              reject_pop;

    logic [CNT_W-1:0]  occ_r;
    logic              full_r;

    modport master (
        output cmd_vld, cmd_op, cmd_tbl, cmd_uid, cmd_qty, reject_pop,
        input  cmd_rdy, rsp_vld_r, rsp_hit_r, rsp_tbl_r, rsp_rem_r,
        input  head_vld_r, head_r, reject_vld_r, reject_r, occ_r, full_r
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_tbl, cmd_uid, cmd_qty, reject_pop,
        output cmd_rdy, rsp_vld_r, rsp_hit_r, rsp_tbl_r, rsp_rem_r,
        output head_vld_r, head_r, reject_vld_r, reject_r, occ_r, full_r
    );
endinterface

// File: rtl/ob_table_slot.sv
// One resting entry of the order table with its next-state source mux.
module ob_table_slot
    import ob_pkg::*;
#(
    parameter bit IS_ASK = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      sel_ins_i,
    input  logic      sel_head_i,
    input  logic      sel_tail_i,
    input  logic      sel_amend_i,
    input  table_t    ins_tbl_i,
    input  slot_t     head_nb_i,
    input  slot_t     tail_nb_i,
    input  quantity_t amend_qty_i,
    output slot_t     ent_o
);

    slot_t ent_q;
    slot_t ent_d;

    // Pick hold, install, shift from either neighbour, or quantity amend
    always_comb begin
        ent_d = slot_next(ent_q, sel_ins_i, sel_head_i, sel_tail_i, sel_amend_i,
                          ins_tbl_i, head_nb_i, tail_nb_i, amend_qty_i);
    end

    // Entry register; reset parks an invalid entry with the side's worst price
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= empty_slot(IS_ASK);
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ent_o = ent_q;

endmodule

// File: rtl/ob_table_fifo.sv
// Sorted price-time-priority table for one book side; head sits in slot N-1.
module ob_table_fifo
    import ob_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter bit          IS_ASK = 1'b1,
    parameter int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    ob_table_fifo_if.slave bus
);

    localparam slot_t EMPTY = empty_slot(IS_ASK);

    slot_t            slot_q [N];

    logic             accept_c;
    logic [N:0]       keep_ext;
    logic [N-1:0]     keep;
    logic [N-1:0]     match;
    logic [N-1:0]     rm_mask;
    logic [N-1:0]     sel_ins;
    logic [N-1:0]     sel_head;
    logic [N-1:0]     sel_tail;
    logic [N-1:0]     sel_amend;
    logic             hit_any;
    slot_t            match_ent;
    slot_t            head_ent;
    quantity_t        amend_qty;

    logic             rsp_vld_q,    rsp_vld_d;
    logic             rsp_hit_q,    rsp_hit_d;
    table_t           rsp_tbl_q,    rsp_tbl_d;
    quantity_t        rsp_rem_q,    rsp_rem_d;
    logic             head_vld_q,   head_vld_d;
    table_t           head_q,       head_d;
    logic             reject_vld_q, reject_vld_d;
    table_t           reject_q,     reject_d;
    logic [CNT_W-1:0] occ_q,        occ_d;
    logic             full_q,       full_d;
    slot_t            head_nxt;

    // Storage slots, each shifting from its head-side or tail-side neighbour
    for (genvar g = 0; g < N; g++) begin : g_slot
        ob_table_slot #(.IS_ASK(IS_ASK)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .sel_ins_i  (sel_ins[g]),
            .sel_head_i (sel_head[g]),
            .sel_tail_i (sel_tail[g]),
            .sel_amend_i(sel_amend[g]),
            .ins_tbl_i  (bus.cmd_tbl),
            .head_nb_i  ((g == N - 1) ? EMPTY : slot_q[(g == N - 1) ? g : g + 1]),
            .tail_nb_i  ((g == 0)     ? EMPTY : slot_q[(g == 0) ? g : g - 1]),
            .amend_qty_i(amend_qty),
            .ent_o      (slot_q[g])
        );
    end

    // Compare/match vectors, per-slot selects and next values of all outputs
    always_comb begin
        accept_c     = bus.cmd_vld & ~reject_vld_q;
        keep         = '0;
        match        = '0;
        rm_mask      = '0;
        sel_ins      = '0;
        sel_head     = '0;
        sel_tail     = '0;
        sel_amend    = '0;
        match_ent    = '0;
        amend_qty    = '0;
        head_ent     = slot_q[N-1];

        rsp_vld_d    = accept_c;
        rsp_hit_d    = 1'b0;
        rsp_tbl_d    = '0;
        rsp_rem_d    = '0;
        occ_d        = occ_q;
        reject_vld_d = reject_vld_q & ~bus.reject_pop;
        reject_d     = bus.reject_pop ? '0 : reject_q;

        for (int i = 0; i < N; i++) begin
            keep[i]  = slot_q[i].vld & ranks_ahead(IS_ASK, slot_q[i].tbl.price, bus.cmd_tbl.price);
            match[i] = slot_q[i].vld & (slot_q[i].tbl.uid == bus.cmd_uid);
            if (match[i]) begin
                match_ent = slot_q[i];
            end
        end
        keep_ext = {1'b1, keep};
        hit_any  = |match;

        // A removal at slot m pulls every slot at or below m up by one
        for (int i = 0; i < N; i++) begin
            for (int j = i; j < N; j++) begin
                rm_mask[i] = rm_mask[i] | match[j];
            end
        end

        if (accept_c) begin
            case (bus.cmd_op)
                INSERT: begin
                    for (int i = 0; i < N; i++) begin
                        sel_ins[i]  = ~keep_ext[i] & keep_ext[i+1];
                        sel_head[i] = ~keep_ext[i] & ~keep_ext[i+1];
                    end
                    if (full_q) begin
                        reject_vld_d = 1'b1;
                        reject_d     = (|sel_ins) ? slot_q[0].tbl : bus.cmd_tbl;
                    end else begin
                        occ_d = occ_q + CNT_W'(1);
                    end
                end
                CANCEL, AMEND: begin
                    if (hit_any) begin
                        rsp_hit_d = 1'b1;
                        rsp_tbl_d = match_ent.tbl;
                        if (bus.cmd_op == AMEND && bus.cmd_qty != '0) begin
                            sel_amend = match;
                            amend_qty = bus.cmd_qty;
                        end else begin
                            sel_tail = rm_mask;
                            occ_d    = occ_q - CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (head_ent.vld) begin
                        rsp_hit_d = 1'b1;
                        rsp_tbl_d = head_ent.tbl;
                        if (bus.cmd_qty < head_ent.tbl.qty) begin
                            sel_amend[N-1] = 1'b1;
                            amend_qty      = head_ent.tbl.qty - bus.cmd_qty;
                        end else begin
                            sel_tail  = '1;
                            rsp_rem_d = bus.cmd_qty - head_ent.tbl.qty;
                            occ_d     = occ_q - CNT_W'(1);
                        end
                    end else begin
                        rsp_rem_d = bus.cmd_qty;
                    end
                end
                default: ;
            endcase
        end

        head_nxt   = slot_next(slot_q[N-1], sel_ins[N-1], sel_head[N-1], sel_tail[N-1],
                               sel_amend[N-1], bus.cmd_tbl, EMPTY, slot_q[N-2], amend_qty);
        head_vld_d = head_nxt.vld;
        head_d     = head_nxt.vld ? head_nxt.tbl : '0;
        full_d     = (occ_d == CNT_W'(N));
    end

    // Response, head, reject and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q    <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_tbl_q    <= '0;
            rsp_rem_q    <= '0;
            head_vld_q   <= 1'b0;
            head_q       <= '0;
            reject_vld_q <= 1'b0;
            reject_q     <= '0;
            occ_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_tbl_q    <= rsp_tbl_d;
            rsp_rem_q    <= rsp_rem_d;
            head_vld_q   <= head_vld_d;
            head_q       <= head_d;
            reject_vld_q <= reject_vld_d;
            reject_q     <= reject_d;
            occ_q        <= occ_d;
            full_q       <= full_d;
        end
    end

    assign bus.cmd_rdy      = ~reject_vld_q;
    assign bus.rsp_vld_r    = rsp_vld_q;
    assign bus.rsp_hit_r    = rsp_hit_q;
    assign bus.rsp_tbl_r    = rsp_tbl_q;
    assign bus.rsp_rem_r    = rsp_rem_q;
    assign bus.head_vld_r   = head_vld_q;
    assign bus.head_r       = head_q;
    assign bus.reject_vld_r = reject_vld_q;
    assign bus.reject_r     = reject_q;
    assign bus.occ_r        = occ_q;
    assign bus.full_r       = full_q;

endmodule

// File: tb/tb_ob_table_fifo.sv
// Scoreboard bench: ask table (N=4) for the functional sequence, bid table (N=8) for mid-command reset.
module tb_ob_table_fifo;
    import ob_pkg::*;

    typedef struct {
        logic      hit;
        bit        ck_tbl;
        table_t    tbl;
        bit        ck_rem;
        quantity_t rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    ob_table_fifo_if #(.CNT_W(3)) bus_a ();
    ob_table_fifo_if #(.CNT_W(4)) bus_b ();

    ob_table_fifo #(.N(4), .IS_ASK(1'b1), .CNT_W(3)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    ob_table_fifo #(.N(8), .IS_ASK(1'b0), .CNT_W(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic table_t mk(input int u, input int p, input int q);
        table_t t;
        t.uid   = uid_t'(u);
        t.price = price_t'(p);
        t.qty   = quantity_t'(q);
        return t;
    endfunction

    function automatic exp_t mk_exp(input logic hit, input bit ck_tbl, input table_t tbl,
                                    input bit ck_rem, input int rem);
        exp_t e;
        e.hit    = hit;
        e.ck_tbl = ck_tbl;
        e.tbl    = tbl;
        e.ck_rem = ck_rem;
        e.rem    = quantity_t'(rem);
        return e;
    endfunction

    task automatic drive_a(input logic vld, input tbl_op_t op, input table_t t, input int u,
                           input int q, input logic pop);
        @(negedge clk);
        bus_a.cmd_vld    = vld;
        bus_a.cmd_op     = op;
        bus_a.cmd_tbl    = t;
        bus_a.cmd_uid    = uid_t'(u);
        bus_a.cmd_qty    = quantity_t'(q);
        bus_a.reject_pop = pop;
        @(posedge clk);
        #1;
        bus_a.cmd_vld    = 1'b0;
        bus_a.reject_pop = 1'b0;
    endtask

    task automatic drive_b(input tbl_op_t op, input table_t t, input int q);
        @(negedge clk);
        bus_b.cmd_vld = 1'b1;
        bus_b.cmd_op  = op;
        bus_b.cmd_tbl = t;
        bus_b.cmd_qty = quantity_t'(q);
        @(posedge clk);
        #1;
        bus_b.cmd_vld = 1'b0;
    endtask

    // Response scoreboards
    always @(negedge clk) begin
        exp_t ea;
        exp_t eb;
        if (bus_a.rsp_vld_r) begin
            if (qa.size() == 0) begin
                chk("a_rsp_pending", 64'(qa.size()), 64'(1));
            end else begin
                ea = qa.pop_front();
                chk("a_rsp_hit", 64'(bus_a.rsp_hit_r), 64'(ea.hit));
                if (ea.ck_tbl) chk("a_rsp_tbl", 64'(bus_a.rsp_tbl_r), 64'(ea.tbl));
                if (ea.ck_rem) chk("a_rsp_rem", 64'(bus_a.rsp_rem_r), 64'(ea.rem));
            end
        end
        if (bus_b.rsp_vld_r) begin
            if (qb.size() == 0) begin
                chk("b_rsp_pending", 64'(qb.size()), 64'(1));
            end else begin
                eb = qb.pop_front();
                chk("b_rsp_hit", 64'(bus_b.rsp_hit_r), 64'(eb.hit));
            end
        end
    end

    // The controller must never present a UID that is resident twice
    always @(negedge clk) begin
        int m;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            if (dut_a.slot_q[i].vld && dut_a.slot_q[i].tbl.uid == bus_a.cmd_uid) m++;
        end
        assert (m <= 1) else $error("duplicate uid %0d in ask table", bus_a.cmd_uid);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.cmd_vld = 1'b0; bus_a.cmd_op = INSERT; bus_a.cmd_tbl = '0;
        bus_a.cmd_uid = '0;   bus_a.cmd_qty = '0;    bus_a.reject_pop = 1'b0;
        bus_b.cmd_vld = 1'b0; bus_b.cmd_op = INSERT; bus_b.cmd_tbl = '0;
        bus_b.cmd_uid = '0;   bus_b.cmd_qty = '0;    bus_b.reject_pop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;

        chk("rst_occ",     64'(bus_a.occ_r),        64'(0));
        chk("rst_headv",   64'(bus_a.head_vld_r),   64'(0));
        chk("rst_head",    64'(bus_a.head_r),       64'(0));
        chk("rst_rdy",     64'(bus_a.cmd_rdy),      64'(1));
        chk("rst_rejv",    64'(bus_a.reject_vld_r), 64'(0));
        chk("rst_full",    64'(bus_a.full_r),       64'(0));
        chk("rst_rspv",    64'(bus_a.rsp_vld_r),    64'(0));

        // Out-of-order inserts land sorted ascending
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(1, 105, 10), 0, 0, 1'b0);
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(2, 101, 20), 0, 0, 1'b0);
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(3, 103, 30), 0, 0, 1'b0);
        chk("ins_head",   64'(bus_a.head_r),            64'(mk(2, 101, 20)));
        chk("ins_occ",    64'(bus_a.occ_r),             64'(3));
        chk("ins_s2",     64'(dut_a.slot_q[2].tbl.price), 64'(103));
        chk("ins_s1",     64'(dut_a.slot_q[1].tbl.price), 64'(105));
        chk("ins_s0v",    64'(dut_a.slot_q[0].vld),     64'(0));

        // Equal price queues behind the older order
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(9, 103, 40), 0, 0, 1'b0);
        chk("tie_s2uid",  64'(dut_a.slot_q[2].tbl.uid), 64'(3));
        chk("tie_s1uid",  64'(dut_a.slot_q[1].tbl.uid), 64'(9));
        chk("tie_s0uid",  64'(dut_a.slot_q[0].tbl.uid), 64'(1));
        chk("tie_full",   64'(bus_a.full_r),            64'(1));
        chk("tie_occ",    64'(bus_a.occ_r),             64'(4));

        // Better price into a full table evicts the tail
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(5, 100, 11), 0, 0, 1'b0);
        chk("ev_rejv",    64'(bus_a.reject_vld_r),      64'(1));
        chk("ev_rej",     64'(bus_a.reject_r),          64'(mk(1, 105, 10)));
        chk("ev_rdy",     64'(bus_a.cmd_rdy),           64'(0));
        chk("ev_head",    64'(bus_a.head_r),            64'(mk(5, 100, 11)));
        chk("ev_occ",     64'(bus_a.occ_r),             64'(4));

        // Command offered while not ready is ignored; pop frees the slot
        drive_a(1'b1, INSERT, mk(7, 99, 1), 0, 0, 1'b1);
        chk("bp_rejv",    64'(bus_a.reject_vld_r),      64'(0));
        chk("bp_rdy",     64'(bus_a.cmd_rdy),           64'(1));
        chk("bp_head",    64'(bus_a.head_r.uid),        64'(5));
        chk("bp_occ",     64'(bus_a.occ_r),             64'(4));

        // Worst-ranked insert into a full table rejects itself
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, INSERT, mk(8, 110, 12), 0, 0, 1'b0);
        chk("self_rej",   64'(bus_a.reject_r),          64'(mk(8, 110, 12)));
        chk("self_rejv",  64'(bus_a.reject_vld_r),      64'(1));
        chk("self_s0",    64'(dut_a.slot_q[0].tbl.uid), 64'(9));
        chk("self_occ",   64'(bus_a.occ_r),             64'(4));
        drive_a(1'b0, INSERT, '0, 0, 0, 1'b1);
        chk("pop_rejv",   64'(bus_a.reject_vld_r),      64'(0));

        // Cancel mid-table; the tail shifts up
        qa.push_back(mk_exp(1'b1, 1, mk(3, 103, 30), 0, 0)); drive_a(1'b1, CANCEL, '0, 3, 0, 1'b0);
        chk("cxl_s1uid",  64'(dut_a.slot_q[1].tbl.uid), 64'(9));
        chk("cxl_s0v",    64'(dut_a.slot_q[0].vld),     64'(0));
        chk("cxl_occ",    64'(bus_a.occ_r),             64'(3));
        chk("cxl_full",   64'(bus_a.full_r),            64'(0));

        // Amend keeps position
        qa.push_back(mk_exp(1'b1, 1, mk(2, 101, 20), 0, 0)); drive_a(1'b1, AMEND, '0, 2, 7, 1'b0);
        chk("amd_s2",     64'(dut_a.slot_q[2].tbl),     64'(mk(2, 101, 7)));
        chk("amd_occ",    64'(bus_a.occ_r),             64'(3));

        // Amend to zero removes
        qa.push_back(mk_exp(1'b1, 1, mk(9, 103, 40), 0, 0)); drive_a(1'b1, AMEND, '0, 9, 0, 1'b0);
        chk("amd0_s1v",   64'(dut_a.slot_q[1].vld),     64'(0));
        chk("amd0_occ",   64'(bus_a.occ_r),             64'(2));

        // Cancel of an absent uid changes nothing
        qa.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_a(1'b1, CANCEL, '0, 77, 0, 1'b0);
        chk("miss_occ",   64'(bus_a.occ_r),             64'(2));
        chk("miss_head",  64'(bus_a.head_r),            64'(mk(5, 100, 11)));

        // Fills against the head
        qa.push_back(mk_exp(1'b1, 1, mk(5, 100, 11), 0, 0)); drive_a(1'b1, AMEND, '0, 5, 50, 1'b0);
        qa.push_back(mk_exp(1'b1, 1, mk(5, 100, 50), 1, 0)); drive_a(1'b1, FILL, '0, 0, 20, 1'b0);
        chk("fp_head",    64'(bus_a.head_r),            64'(mk(5, 100, 30)));
        chk("fp_occ",     64'(bus_a.occ_r),             64'(2));
        qa.push_back(mk_exp(1'b1, 1, mk(5, 100, 30), 1, 15)); drive_a(1'b1, FILL, '0, 0, 45, 1'b0);
        chk("fx_head",    64'(bus_a.head_r),            64'(mk(2, 101, 7)));
        chk("fx_occ",     64'(bus_a.occ_r),             64'(1));
        qa.push_back(mk_exp(1'b1, 1, mk(2, 101, 7), 1, 0)); drive_a(1'b1, FILL, '0, 0, 7, 1'b0);
        chk("feq_occ",    64'(bus_a.occ_r),             64'(0));
        chk("feq_headv",  64'(bus_a.head_vld_r),        64'(0));
        chk("feq_head",   64'(bus_a.head_r),            64'(0));
        qa.push_back(mk_exp(1'b0, 0, '0, 1, 9)); drive_a(1'b1, FILL, '0, 0, 9, 1'b0);
        chk("fe_occ",     64'(bus_a.occ_r),             64'(0));

        repeat (2) @(posedge clk);
        #1;
        chk("a_q_drain",  64'(qa.size()),               64'(0));

        // Bid side: descending price at head, then reset during an accepted FILL
        @(negedge clk);
        rst_b = 1'b0;
        qb.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_b(INSERT, mk(1, 50, 5), 0);
        qb.push_back(mk_exp(1'b0, 0, '0, 0, 0)); drive_b(INSERT, mk(2, 60, 6), 0);
        chk("bid_head",   64'(bus_b.head_r),            64'(mk(2, 60, 6)));
        chk("bid_occ",    64'(bus_b.occ_r),             64'(2));
        @(negedge clk);
        bus_b.cmd_vld = 1'b1;
        bus_b.cmd_op  = FILL;
        bus_b.cmd_qty = quantity_t'(3);
        rst_b         = 1'b1;
        @(posedge clk);
        #1;
        bus_b.cmd_vld = 1'b0;
        chk("brst_rspv",  64'(bus_b.rsp_vld_r),         64'(0));
        chk("brst_occ",   64'(bus_b.occ_r),             64'(0));
        chk("brst_headv", 64'(bus_b.head_vld_r),        64'(0));
        chk("brst_head",  64'(bus_b.head_r),            64'(0));
        chk("brst_rdy",   64'(bus_b.cmd_rdy),           64'(1));
        chk("brst_full",  64'(bus_b.full_r),            64'(0));
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("brel_rspv",  64'(bus_b.rsp_vld_r),         64'(0));
        chk("b_q_drain",  64'(qb.size()),               64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
